// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Optional feature: MDU_MADD_EN makes madd/maddu/msub/msubu real compute ops.
package mdu_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic isDivOp(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isComputeOp(input logic [MD_OP_W-1:0] op);
    logic c;
    c = (op == MD_MULT) || (op == MD_MULTU) || isDivOp(op);
`ifdef MDU_MADD_EN
    c = c || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    c = c || 1'b0;
`endif
    return c;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: produces the 64-bit {hi,lo} result for one op.
// The accumulate ops are always computed here; whether they may start is decided by the package.
module mdu_arith import mdu_pkg::*; (
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [31:0]        a_i,
  input  logic [31:0]        b_i,
  input  logic [31:0]        hi_i,
  input  logic [31:0]        lo_i,
  output logic [63:0]        result_o,
  output logic               div0_o
);

  logic signed [63:0] sProd;
  logic [63:0]        uProd;
  logic [63:0]        acc;
  logic               sOverflow;
  logic [31:0]        sDivisor;
  logic [31:0]        uDivisor;
  logic signed [31:0] sQuot;
  logic signed [31:0] sRem;
  logic [31:0]        uQuot;
  logic [31:0]        uRem;

  assign acc   = {hi_i, lo_i};
  assign sProd = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uProd = {32'd0, a_i} * {32'd0, b_i};

  // Divisor 0 and the signed -2^31/-1 overflow are steered to a divide-by-1, which gives
  // the architected overflow answer directly and keeps the dividers free of X.
  assign div0_o    = (b_i == 32'd0);
  assign sOverflow = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign sDivisor  = (div0_o || sOverflow) ? 32'd1 : b_i;
  assign uDivisor  = div0_o ? 32'd1 : b_i;
  assign sQuot     = $signed(a_i) / $signed(sDivisor);
  assign sRem      = $signed(a_i) % $signed(sDivisor);
  assign uQuot     = a_i / uDivisor;
  assign uRem      = a_i % uDivisor;

  always_comb begin
    result_o = acc;
    case (op_i)
      MD_MULT:  result_o = $unsigned(sProd);
      MD_MULTU: result_o = uProd;
      MD_DIV:   result_o = {$unsigned(sRem), $unsigned(sQuot)};
      MD_DIVU:  result_o = {uRem, uQuot};
      MD_MADD:  result_o = acc + $unsigned(sProd);
      MD_MADDU: result_o = acc + uProd;
      MD_MSUB:  result_o = acc - $unsigned(sProd);
      MD_MSUBU: result_o = acc - uProd;
      default:  result_o = acc;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs compute ops over a fixed busy period.
// Build option MDU_MADD_EN (see mdu_pkg) adds the madd/msub accumulate family.
module ex_mdu import mdu_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               md_start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        md_a,
  input  logic [31:0]        md_b,
  input  logic               md_rsel,
  output logic               busy,
  output logic               md_stall_src,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic [31:0]        md_rdata
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pendWr_q, pendWr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] arithRes;
  logic        arithDiv0;
  logic        startValid;

  mdu_arith uArith (
    .op_i     (md_op),
    .a_i      (md_a),
    .b_i      (md_b),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .result_o (arithRes),
    .div0_o   (arithDiv0)
  );

  assign startValid = md_start && (state_q == MD_IDLE) && isComputeOp(md_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= 4'd0;
      pend_q   <= 64'd0;
      pendWr_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pendWr_q <= pendWr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // The result is captured at the start edge; RUN only counts down and commits at the end.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pendWr_d = pendWr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (startValid) begin
          state_d  = MD_RUN;
          cnt_d    = isDivOp(md_op) ? DIV_CNT : MULT_CNT;
          pend_d   = arithRes;
          pendWr_d = !(isDivOp(md_op) && arithDiv0);
        end else if (!md_start && (md_op == MD_MTHI)) begin
          hi_d = md_a;
        end else if (!md_start && (md_op == MD_MTLO)) begin
          lo_d = md_a;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = MD_IDLE;
          cnt_d   = 4'd0;
          if (pendWr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy         = (state_q == MD_RUN);
  assign md_stall_src = md_start | busy;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign md_rdata     = md_rsel ? hi_q : lo_q;

endmodule
